ctrl_fsm: RTL and testbench
===========================

// Module: ctrl_fsm
// PURPOSE
//  Parametrised multi-cycle control unit for the accumulator-style core. Latches one
//  instruction word per fetch and decodes it into ALU/jump/register/memory controls.
//  Sequences each instruction through FETCH/EXEC/MEM/WB and handshakes with instr and
//  data memory. Reports halt, memory timeout and retired-instruction count.
// PARAMETERS
//  ALUW     2   Aluop field width
//  JW       2   Jptr field width
//  RAW      2   register address width
//  IW       9   instruction width; must equal ALUW+JW+RAW+3
//  TIMEOUT  16  max MEM cycles without mem_ack before fault (>=1)
//  CNTW     16  retired-instruction counter width
// PORTS
//  Clk          in   1     clock, all state updates on rising edge
//  Reset        in   1     synchronous, active-high
//  start        in   1     leave IDLE; ignored in any other state
//  instr_in     in   IW    instruction word, sampled when instr_req & instr_valid
//  instr_valid  in   1     instruction memory has data
//  mem_ack      in   1     data memory completed request
//  instr_req    out  1     fetch request
//  Aluop        out  ALUW  IR[ALUW-1:0]
//  Jptr         out  JW    IR[ALUW+JW-1:ALUW]
//  Ra, Wd       out  RAW   IR[ALUW+JW+RAW-1:ALUW+JW]
//  Rb           out  RAW   constant 0
//  WenR         out  1     register file write enable
//  WenD, Str    out  1     data memory write enable / store
//  Ldr          out  1     load in progress
//  mem_req      out  1     data memory request
//  pc_adv       out  1     1-cycle pulse: instruction retired, advance PC
//  busy         out  1     state is not IDLE and not HALT
//  done         out  1     state is HALT
//  timeout_err  out  1     sticky; set on MEM timeout
//  instr_count  out  CNTW  retired instructions, saturating
// BEHAVIOUR
//  Instruction fields above ALU/J/R: bit W=IR[IW-3], bit L=IR[IW-2], bit H=IR[IW-1].
//  Class: H=1 HALT; else L=1 LOAD; else W=1 ALU; else STORE.
//  All outputs decode from state register and IR only. No input-to-output paths.
//  Reset: state IDLE, IR=0, wait counter=0, instr_count=0, timeout_err=0. Every output is 0.
//  IDLE: start -> FETCH.
//  FETCH: instr_req=1; on instr_valid, IR<=instr_in, -> EXEC. Otherwise hold.
//  EXEC, exactly 1 cycle:
//   ALU: WenR=1, pc_adv=1, -> FETCH.
//   LOAD/STORE: -> MEM, wait counter cleared.
//   HALT: -> HALT.
//  MEM: mem_req=1. STORE also drives WenD=Str=1; LOAD also drives Ldr=1.
//   On mem_ack, STORE: pc_adv=1, -> FETCH. LOAD: -> WB.
//   No ack: counter++. When counter==TIMEOUT-1 without ack: timeout_err<=1, -> HALT, no retire.
//   An ack in the same cycle as the timeout wins; the fault is not raised.
//  WB, 1 cycle: WenR=1, Ldr=1, pc_adv=1, -> FETCH.
//  HALT: done=1. Exit only via Reset. start is ignored here.
//  instr_count += 1 on each pc_adv and saturates at all-ones. HALT does not count.
//  Minimum cycles per instruction with zero-wait memory: ALU 2, STORE 3, LOAD 4.
//  Reset mid-instruction: aborts it, no pulse is emitted, next cycle is the reset state.
// TESTING
//  1 Reset, start, instr_in=9'h067 valid at once -> EXEC cycle: WenR=1, Aluop=3, Jptr=1,
//    Ra=Wd=2, pc_adv=1; instr_count=1; back in FETCH.
//  2 Store 9'h010, mem_ack in 3rd MEM cycle -> mem_req=WenD=Str=1 for 3 cycles, Ra=1,
//    WenR=0, then pc_adv=1 in the ack cycle.
//  3 Load 9'h0A0, immediate ack -> MEM 1 cycle with Ldr=1, then WB: WenR=1, Ldr=1,
//    Wd=2, pc_adv=1.
//  4 TIMEOUT=4, store with no ack -> 4 MEM cycles, then HALT: done=1, timeout_err=1,
//    instr_count unchanged. Repeat with ack in the 4th cycle -> no fault.
//  5 Halt 9'h100 -> EXEC then HALT: done=1, busy=0, no pc_adv; start pulses ignored.
//  6 Reset asserted mid-MEM of a load -> next cycle all outputs 0, instr_count=0, IDLE.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit for the accumulator core: fetches one instruction, decodes it
// and sequences FETCH/EXEC/MEM/WB with instruction- and data-memory handshakes.
module ctrl_fsm #(
    parameter int ALUW    = 2,
    parameter int JW      = 2,
    parameter int RAW     = 2,
    parameter int IW      = 9,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic [IW-1:0]   instr_in,
    input  logic            instr_valid,
    input  logic            mem_ack,
    output logic            instr_req,
    output logic [ALUW-1:0] Aluop,
    output logic [JW-1:0]   Jptr,
    output logic [RAW-1:0]  Ra,
    output logic [RAW-1:0]  Wd,
    output logic [RAW-1:0]  Rb,
    output logic            WenR,
    output logic            WenD,
    output logic            Str,
    output logic            Ldr,
    output logic            mem_req,
    output logic            pc_adv,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [CNTW-1:0] instr_count,
    output logic [2:0]      state_dbg
);

    // Handshakes: an instruction transfers on a rising edge where instr_req and instr_valid
    // are both high; a data access completes on a rising edge where mem_req and mem_ack are
    // both high. instr_req/mem_req are held until the transfer completes (or MEM times out).
    localparam int WAITW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    ir;
    logic [WAITW-1:0] wait_cnt;
    logic             is_halt, is_load, is_alu;
    logic             timeout_hit;

    // Class priority: H over L over W; none of them set means STORE.
    assign is_halt = ir[IW-1];
    assign is_load = !ir[IW-1] && ir[IW-2];
    assign is_alu  = !ir[IW-1] && !ir[IW-2] && ir[IW-3];

    assign Aluop     = ir[ALUW-1:0];
    assign Jptr      = ir[ALUW+JW-1:ALUW];
    assign Ra        = ir[ALUW+JW+RAW-1:ALUW+JW];
    assign Wd        = ir[ALUW+JW+RAW-1:ALUW+JW];
    assign Rb        = '0;
    assign state_dbg = state;

    // An ack arriving on the last allowed cycle takes priority over the fault.
    assign timeout_hit = (state == S_MEM) && !mem_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            ir          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid)
                ir <= instr_in;
            if (state == S_EXEC)
                wait_cnt <= '0;
            else if (state == S_MEM && !mem_ack)
                wait_cnt <= wait_cnt + WAITW'(1);
            if (timeout_hit)
                timeout_err <= 1'b1;
            if (pc_adv && instr_count != {CNTW{1'b1}})
                instr_count <= instr_count + CNTW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        WenR      = 1'b0;
        WenD      = 1'b0;
        Str       = 1'b0;
        Ldr       = 1'b0;
        mem_req   = 1'b0;
        pc_adv    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                instr_req = 1'b1;
                if (instr_valid)
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else if (is_alu) begin
                    WenR      = 1'b1;
                    pc_adv    = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_MEM;
                end
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (is_load) begin
                    Ldr = 1'b1;
                end else begin
                    WenD = 1'b1;
                    Str  = 1'b1;
                end
                if (mem_ack) begin
                    if (is_load) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_adv    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                busy      = 1'b1;
                WenR      = 1'b1;
                Ldr       = 1'b1;
                pc_adv    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomised bench for ctrl_fsm: a driver issues instructions and memory responses, a
// reference model predicts each retire/halt event, and a monitor compares on every event.
module tb_ctrl_fsm;

    localparam int T = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] instr_in = '0;
    logic       instr_valid = 1'b0;
    logic       mem_ack = 1'b0;
    logic       instr_req, WenR, WenD, Str, Ldr, mem_req, pc_adv, busy, done, timeout_err;
    logic [1:0] Aluop, Jptr, Ra, Wd, Rb;
    logic [3:0] instr_count;
    logic [2:0] state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    ctrl_fsm #(.ALUW(2), .JW(2), .RAW(2), .IW(9), .TIMEOUT(T), .CNTW(4)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .instr_in(instr_in),
        .instr_valid(instr_valid), .mem_ack(mem_ack), .instr_req(instr_req),
        .Aluop(Aluop), .Jptr(Jptr), .Ra(Ra), .Wd(Wd), .Rb(Rb), .WenR(WenR),
        .WenD(WenD), .Str(Str), .Ldr(Ldr), .mem_req(mem_req), .pc_adv(pc_adv),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    function automatic logic [3:0] sat(input int r);
        return (r > 15) ? 4'd15 : 4'(r);
    endfunction

    // Event record seen at a retire pulse or at the first HALT cycle.
    function automatic logic [31:0] ev(input logic kind, input logic [1:0] a, input logic [1:0] j,
                                       input logic [1:0] ra, input logic [1:0] wd, input logic [1:0] rb,
                                       input logic wenr, input logic wend, input logic str,
                                       input logic ldr, input logic mreq, input logic bsy,
                                       input logic dn, input logic terr, input logic [3:0] cnt,
                                       input logic [7:0] lat);
        return {1'b0, kind, a, j, ra, wd, rb, wenr, wend, str, ldr, mreq, bsy, dn, terr, cnt, lat};
    endfunction

    function automatic logic [23:0] outs_all();
        return {instr_req, Aluop, Jptr, Ra, Wd, Rb, WenR, WenD, Str, Ldr, mem_req, pc_adv,
                busy, done, timeout_err, instr_count};
    endfunction

    // Reference model: what the next event must look like for instruction w, given k idle
    // memory cycles before the ack (k >= T means the ack never comes).
    task automatic predict(input logic [8:0] w, input int k, inout int retired);
        logic [1:0] a, j, r;
        a = w[1:0];
        j = w[3:2];
        r = w[5:4];
        if (w[8]) begin
            exp_q.push_back(ev(1, a, j, r, r, 0, 0, 0, 0, 0, 0, 0, 1, 0, sat(retired), 8'd2));
        end else if (w[6] && !w[7]) begin
            exp_q.push_back(ev(0, a, j, r, r, 0, 1, 0, 0, 0, 0, 1, 0, 0, sat(retired), 8'd1));
            retired++;
        end else if (k >= T) begin
            exp_q.push_back(ev(1, a, j, r, r, 0, 0, 0, 0, 0, 0, 0, 1, 1, sat(retired), 8'(T + 2)));
        end else if (w[7]) begin
            exp_q.push_back(ev(0, a, j, r, r, 0, 1, 0, 0, 1, 0, 1, 0, 0, sat(retired), 8'(k + 3)));
            retired++;
        end else begin
            exp_q.push_back(ev(0, a, j, r, r, 0, 0, 1, 1, 0, 1, 1, 0, 0, sat(retired), 8'(k + 2)));
            retired++;
        end
    endtask

    // driver: one instruction, d cycles of instr_valid low, k cycles before mem_ack
    task automatic run_instr(input logic [8:0] w, input int d, input int k,
                             inout int retired, output bit ended);
        int guard;
        ended = 1'b0;
        guard = 0;
        while (!instr_req && guard < 50) begin
            step();
            guard++;
        end
        if (!instr_req) begin
            n_total++;
            $display("FAIL fetch_wait: got no instr_req, required instr_req within 50 cycles");
            ended = 1'b1;
            return;
        end
        repeat (d) step();
        predict(w, k, retired);
        instr_in    = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        if (w[8]) begin
            step();
            ended = 1'b1;
            return;
        end
        if (w[6] && !w[7]) return;
        step();
        if (k < T) begin
            repeat (k) step();
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end else begin
            repeat (T) step();
            ended = 1'b1;
        end
    endtask

    task automatic reset_start();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("reset_outputs", 32'(outs_all()), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt_tail(input int retired);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check("halt_hold", 32'({done, busy, instr_req, pc_adv}), 32'b1000);
        check("halt_count", 32'(instr_count), 32'(sat(retired)));
    endtask

    function automatic logic [8:0] make_word(input int cls);
        logic [8:0] w;
        w = 9'($urandom_range(0, 511));
        case (cls)
            0: w[8:6] = 3'b001;
            1: w[8:6] = 3'b000;
            2: w[8:7] = 2'b01;
            default: w[8] = 1'b1;
        endcase
        return w;
    endfunction

    // monitor / scoreboard
    int   lat = 0;
    logic prev_done = 1'b0;

    always @(negedge Clk) begin
        if (Reset) begin
            lat       = 0;
            prev_done = 1'b0;
        end else begin
            if (instr_req && instr_valid) lat = 0;
            else if (lat < 255) lat++;
            if (pc_adv || (done && !prev_done)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: got pc_adv=%0b done=%0b, required no event",
                             pc_adv, done);
                end else begin
                    check("event", ev(done, Aluop, Jptr, Ra, Wd, Rb, WenR, WenD, Str, Ldr,
                                      mem_req, busy, done, timeout_err, instr_count, 8'(lat)),
                          exp_q.pop_front());
                end
            end
            prev_done = done;
        end
    end

    // stimulus
    initial begin
        int  retired;
        bit  ended;
        int  cls, k;
        step();

        // ALU, store with 2 waits, zero-wait load, store acked on last cycle, store timeout
        reset_start();
        retired = 0;
        run_instr(9'h067, 0, 0, retired, ended);
        run_instr(9'h010, 1, 2, retired, ended);
        run_instr(9'h0A0, 0, 0, retired, ended);
        run_instr(9'h010, 0, T - 1, retired, ended);
        run_instr(9'h010, 2, T, retired, ended);
        halt_tail(retired);

        // halt instruction
        reset_start();
        retired = 0;
        run_instr(9'h100, 0, 0, retired, ended);
        halt_tail(retired);

        // counter saturation
        reset_start();
        retired = 0;
        for (int i = 0; i < 20; i++) run_instr(make_word(0), 0, 0, retired, ended);
        run_instr(make_word(3), 0, 0, retired, ended);
        halt_tail(retired);

        // reset in the middle of a load's MEM phase
        reset_start();
        retired = 0;
        run_instr(9'h067, 0, 0, retired, ended);
        while (!instr_req) step();
        instr_in    = 9'h0A0;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid_mem_reset", 32'(outs_all()), 32'd0);

        // random programs
        for (int s = 0; s < 12; s++) begin
            reset_start();
            retired = 0;
            ended   = 1'b0;
            for (int i = 0; i < 24 && !ended; i++) begin
                cls = (i == 23) ? 3 : (($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2));
                k   = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
                run_instr(make_word(cls), $urandom_range(0, 2), k, retired, ended);
            end
            halt_tail(retired);
        end

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
